sr_drive_ctrl: RTL and testbench

//   Upstream command stage for the NAND-based SR flip-flop (ports S, R, clk, Q, Qn).
//   - Accepts SET/RESET/TOGGLE/NOP commands on a valid/ready handshake.
//   - Converts each command into a registered, fixed-width S or R pulse. S=R=1 (the forbidden input) is never driven.
//   - Tracks the expected flip-flop state and checks it against the Q feedback after every pulse.

---
 rtl/sr_drive_ctrl.sv | 76 +++++++
 tb/tb_sr_drive_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sr_drive_ctrl.sv
// sr_drive_ctrl: turns SET/RESET/TOGGLE commands into gated S/R pulses and checks Q feedback
module sr_drive_ctrl #(
  parameter int PULSE_W   = 2,
  parameter int GAP_W     = 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  input  logic [1:0]           cmd_op,
  output logic                 cmd_ready,
  input  logic                 err_clr,
  input  logic                 Q_fb,
  output logic                 S,
  output logic                 R,
  output logic                 exp_q,
  output logic                 busy,
  output logic                 mismatch,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  localparam int CW = $clog2((PULSE_W > GAP_W ? PULSE_W : GAP_W) + 1);
  localparam logic [CW-1:0] P_END = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] G_END = CW'(GAP_W - 1);
  typedef enum logic [2:0] {INIT, IDLE, PULSE, GAP, CHECK} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic tgt, fail, last;
  always_comb begin
    tgt  = cmd_op == 2'b01 ? 1'b1 : cmd_op == 2'b10 ? 1'b0 : ~exp_q;
    fail = state == CHECK && Q_fb != exp_q;
    last = cnt == (state == PULSE ? P_END : G_END);
  end
  assign cmd_ready = state == IDLE && !rst;
  assign busy      = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      cnt      <= '0;
      S        <= 1'b0;
      R        <= 1'b0;
      exp_q    <= 1'b0;
      mismatch <= 1'b0;
      err_cnt  <= '0;
    end else begin
      mismatch <= fail | (mismatch & ~err_clr);
      err_cnt  <= err_clr ? ERR_CNT_W'(fail) : err_cnt + ERR_CNT_W'(fail && !(&err_cnt));
      case (state)
        INIT: begin
          state <= PULSE;
          S     <= 1'b0;
          R     <= 1'b1;
        end
        IDLE: if (cmd_valid && cmd_op != 2'b00) begin
          state <= PULSE;
          exp_q <= tgt;
          S     <= tgt;
          R     <= ~tgt;
        end
        PULSE: begin
          cnt <= last ? '0 : cnt + CW'(1);
          if (last) begin
            state <= GAP;
            S     <= 1'b0;
            R     <= 1'b0;
          end
        end
        GAP: begin
          cnt <= last ? '0 : cnt + CW'(1);
          if (last) state <= CHECK;
        end
        CHECK: state <= IDLE;
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_sr_drive_ctrl.sv
// tb_sr_drive_ctrl: directed scoreboard bench for sr_drive_ctrl with a behavioural flip-flop on Q_fb
module tb_sr_drive_ctrl;
  localparam int PW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic err_clr = 1'b0;
  logic Q_fb, cmd_ready, S, R, exp_q, busy, mismatch;
  logic [7:0] err_cnt;
  logic ffq = 1'b1;
  logic stuck = 1'b0;
  logic m_exp = 1'b0;
  logic m_mis = 1'b0;
  int m_err = 0;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  logic sb[$];
  logic in_pulse = 1'b0;
  logic abort = 1'b0;
  int plen = 0;
  logic [1:0] ops [6] = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b01, 2'b10};
  sr_drive_ctrl #(.PULSE_W(PW), .GAP_W(1), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .err_clr(err_clr), .Q_fb(Q_fb), .S(S), .R(R), .exp_q(exp_q), .busy(busy),
    .mismatch(mismatch), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  assign Q_fb = stuck ? 1'b0 : ffq;
  always @(posedge clk) begin
    cyc++;
    if (S) ffq <= 1'b1;
    else if (R) ffq <= 1'b0;
    if (rst && (S || R)) abort = 1'b1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask
  always @(negedge clk) begin
    chk("s_and_r", S && R, 1'b0);
    if ((S || R) && !in_pulse) begin
      in_pulse = 1'b1;
      plen = 1;
      if (sb.size() == 0) chk("unexpected_pulse", {S, R}, 2'b00);
      else begin
        logic t;
        t = sb.pop_front();
        chk("pulse_S", S, t);
        chk("pulse_R", R, !t);
      end
    end else if (S || R) plen++;
    else if (in_pulse) begin
      in_pulse = 1'b0;
      if (!abort) chk("pulse_len", plen, PW);
      abort = 1'b0;
    end
  end
  task automatic note_accept(input logic [1:0] op);
    logic t;
    if (op == 2'b00) return;
    t = op == 2'b01 ? 1'b1 : op == 2'b10 ? 1'b0 : ~m_exp;
    sb.push_back(t);
    m_exp = t;
    if ((stuck ? 1'b0 : t) != t) begin
      m_mis = 1'b1;
      if (m_err != 255) m_err++;
    end
  endtask
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, cmd_ready, 1'b1);
  endtask
  task automatic check_model(input string tag);
    chk({tag, "_exp_q"}, exp_q, m_exp);
    chk({tag, "_mismatch"}, mismatch, m_mis);
    chk({tag, "_err_cnt"}, err_cnt, m_err);
  endtask
  task automatic do_cmd(input logic [1:0] op);
    wait_ready("ready_before");
    cmd_valid = 1'b1;
    cmd_op = op;
    note_accept(op);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom);
    wait_ready("ready_after");
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int last, idx, quiet;
    repeat (3) @(negedge clk);
    chk("rst_S", S, 1'b0);
    chk("rst_R", R, 1'b0);
    chk("rst_ready", cmd_ready, 1'b0);
    chk("rst_busy", busy, 1'b1);
    check_model("rst");
    rst = 1'b0;
    sb.push_back(1'b0);
    @(negedge clk);
    chk("init_c1_R", R, 1'b1);
    chk("init_c1_S", S, 1'b0);
    @(negedge clk);
    chk("init_c2_R", R, 1'b1);
    @(negedge clk);
    chk("init_c3_SR", {S, R}, 2'b00);
    chk("init_c3_busy", busy, 1'b1);
    @(negedge clk);
    chk("init_c4_ready", cmd_ready, 1'b0);
    @(negedge clk);
    chk("init_c5_ready", cmd_ready, 1'b1);
    check_model("init");
    do_cmd(2'b01);
    check_model("set");
    do_cmd(2'b11);
    check_model("toggle");
    last = -1;
    idx = 0;
    cmd_valid = 1'b1;
    cmd_op = ops[0];
    for (int c = 0; c < 60 && idx < 6; c++) begin
      if (cmd_ready) begin
        if (last >= 0) chk("accept_gap", cyc - last, 5);
        last = cyc;
        note_accept(cmd_op);
        idx++;
        @(negedge clk);
        cmd_op = idx < 6 ? ops[idx] : 2'b00;
      end else @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("accept_count", idx, 6);
    wait_ready("stream_done");
    check_model("stream");
    cmd_valid = 1'b1;
    cmd_op = 2'b01;
    note_accept(2'b01);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_rst_S_on", S, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_SR", {S, R}, 2'b00);
    chk("mid_rst_busy", busy, 1'b1);
    chk("mid_rst_ready", cmd_ready, 1'b0);
    m_exp = 1'b0;
    m_mis = 1'b0;
    m_err = 0;
    check_model("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    sb.push_back(1'b0);
    @(negedge clk);
    chk("reinit_R", R, 1'b1);
    wait_ready("reinit_done");
    check_model("reinit");
    stuck = 1'b1;
    do_cmd(2'b01);
    check_model("fail1");
    for (int k = 0; k < 300; k++) do_cmd(2'b01);
    check_model("saturate");
    chk("sat_value", err_cnt, 8'hff);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_mis = 1'b0;
    m_err = 0;
    check_model("clear");
    for (int k = 0; k < 3; k++) do_cmd(2'b01);
    check_model("three");
    cmd_valid = 1'b1;
    cmd_op = 2'b01;
    note_accept(2'b01);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("in_check_busy", busy, 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_mis = 1'b1;
    m_err = 1;
    chk("clr_fail_ready", cmd_ready, 1'b1);
    check_model("clr_fail");
    do_cmd(2'b00);
    quiet = 0;
    repeat (6) begin
      @(negedge clk);
      if (S || R) quiet++;
    end
    chk("nop_quiet", quiet, 0);
    check_model("nop");
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
